morse_key_sched: RTL

- Front-end sequencer for the Morse receive decoder.
- Takes one raw straight-key input and measures press and release durations in Morse time units.
- Converts them into the decoder's command strobes: dot, dash, clear and letter-confirm.
- Replaces the manual dot/dash/clear/confirm push-buttons, so the decoder runs from a single key with automatic letter-gap confirmation.

---
 rtl/morse_pkg.sv | 23 ++
 rtl/key_sync_deb.sv | 58 +++++
 rtl/morse_key_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key front-end, decoder and bench:
// FSM state encoding and default timing constants.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int CLK_PER_UNIT_DEF = 50000;
  localparam int DEB_CYCLES_DEF   = 16;
  localparam int DASH_UNITS_DEF   = 2;
  localparam int LETTER_UNITS_DEF = 3;
  localparam int CANCEL_UNITS_DEF = 10;
  localparam int MAX_SYMS_DEF     = 4;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/key_sync_deb.sv
// Two-flop synchroniser and debouncer for an active-low raw key.
// o_kp (1 = pressed) flips only after DEB_CYCLES consecutive cycles of the new level.
module key_sync_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_kp,
  output logic o_kp_rise,
  output logic o_kp_fall
);

  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_kp;
  logic             r_rise;
  logic             r_fall;
  logic             w_pressed;

  assign w_pressed = ~r_sync[1];

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the synchroniser chain shifts one stage per clock instead of collapsing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_kp   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_pressed != r_kp) begin
        if (r_cnt == CNT_LAST) begin
          r_kp   <= w_pressed;
          r_cnt  <= '0;
          r_rise <= w_pressed;
          r_fall <= ~w_pressed;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_kp      = r_kp;
  assign o_kp_rise = r_rise;
  assign o_kp_fall = r_fall;

endmodule

// File: rtl/morse_key_sched.sv
// Single straight-key front-end: measures press/gap lengths in Morse units and
// issues dot, dash, clear and confirm strobes to the receive decoder.
module morse_key_sched
  import morse_pkg::*;
#(
  parameter int CLK_PER_UNIT = CLK_PER_UNIT_DEF,
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int DASH_UNITS   = DASH_UNITS_DEF,
  parameter int LETTER_UNITS = LETTER_UNITS_DEF,
  parameter int CANCEL_UNITS = CANCEL_UNITS_DEF,
  parameter int MAX_SYMS     = MAX_SYMS_DEF
) (
  input  logic       wiCLK,
  input  logic       wrst,
  input  logic       wKEY,
  input  logic       wSW,
  output logic       oDot,
  output logic       oDash,
  output logic       oClear,
  output logic       oConfirm,
  output logic       oErr,
  output logic [2:0] oSymCnt,
  output logic [1:0] oState
);

  localparam int PRE_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_UNIT - 1);
  // The clearing cycle is itself the first cycle of the new interval.
  localparam logic [PRE_W-1:0] PRE_LOAD = (CLK_PER_UNIT > 1) ? PRE_W'(1) : '0;
  localparam logic [3:0] DASH_U    = 4'(DASH_UNITS);
  localparam logic [3:0] LETTER_M1 = 4'(LETTER_UNITS - 1);
  localparam logic [3:0] CANCEL_M1 = 4'(CANCEL_UNITS - 1);
  localparam logic [2:0] SYM_MAX   = 3'(MAX_SYMS);

  logic w_kp, w_kp_rise, w_kp_fall;

  key_sync_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .i_clk     (wiCLK),
    .i_rst     (wrst),
    .i_key_n   (wKEY),
    .o_kp      (w_kp),
    .o_kp_rise (w_kp_rise),
    .o_kp_fall (w_kp_fall)
  );

  state_t           r_state, w_state_nx;
  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_units;
  logic [2:0]       r_symcnt, w_sym_nx;
  logic             r_dot, r_dash, r_clear, r_confirm, r_err;
  logic             w_dot_nx, w_dash_nx, w_clear_nx, w_confirm_nx, w_err_nx;
  logic             w_tick, w_clr, w_reach_letter, w_reach_cancel;

  assign w_tick         = (r_pre == PRE_LAST);
  assign w_reach_letter = w_tick && (r_units == LETTER_M1);
  assign w_reach_cancel = w_tick && (r_units == CANCEL_M1);
  assign w_clr          = (w_state_nx != r_state) || w_kp_rise || w_kp_fall;

  always_ff @(posedge wiCLK or posedge wrst) begin
    if (wrst) begin
      r_pre   <= '0;
      r_units <= '0;
    end else if (w_clr) begin
      r_pre   <= PRE_LOAD;
      r_units <= '0;
    end else if (w_tick) begin
      r_pre   <= '0;
      r_units <= sat_inc4(r_units);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nx   = r_state;
    w_sym_nx     = r_symcnt;
    w_dot_nx     = 1'b0;
    w_dash_nx    = 1'b0;
    w_clear_nx   = 1'b0;
    w_confirm_nx = 1'b0;
    w_err_nx     = 1'b0;
    if (wSW) begin
      w_state_nx = ST_IDLE;
      w_sym_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_kp_rise) w_state_nx = ST_PRESS;
        ST_PRESS: begin
          // A release always beats a coincident cancel threshold.
          if (w_kp_fall) begin
            if (r_symcnt == SYM_MAX) begin
              w_clear_nx = 1'b1;
              w_err_nx   = 1'b1;
              w_sym_nx   = '0;
              w_state_nx = ST_IDLE;
            end else begin
              w_dash_nx  = (r_units >= DASH_U);
              w_dot_nx   = (r_units < DASH_U);
              w_sym_nx   = r_symcnt + 3'd1;
              w_state_nx = ST_GAP;
            end
          end else if (w_reach_cancel && w_kp) begin
            w_clear_nx = 1'b1;
            w_sym_nx   = '0;
            w_state_nx = ST_HOLD;
          end
        end
        ST_GAP: begin
          if (w_kp_rise) begin
            w_state_nx = ST_PRESS;
          end else if (w_reach_letter) begin
            w_confirm_nx = 1'b1;
            w_sym_nx     = '0;
            w_state_nx   = ST_IDLE;
          end
        end
        ST_HOLD: if (!w_kp) w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wiCLK or posedge wrst) begin
    if (wrst) begin
      r_state   <= ST_IDLE;
      r_symcnt  <= '0;
      r_dot     <= 1'b0;
      r_dash    <= 1'b0;
      r_clear   <= 1'b0;
      r_confirm <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_symcnt  <= w_sym_nx;
      r_dot     <= w_dot_nx;
      r_dash    <= w_dash_nx;
      r_clear   <= w_clear_nx;
      r_confirm <= w_confirm_nx;
      r_err     <= w_err_nx;
    end
  end

  assign oDot     = r_dot;
  assign oDash    = r_dash;
  assign oClear   = r_clear;
  assign oConfirm = r_confirm;
  assign oErr     = r_err;
  assign oSymCnt  = r_symcnt;
  assign oState   = r_state;

endmodule
